// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU, single-cycle logic/arith ops plus iterative MUL and optional DIVU
// Ports: clock, reset (sync, active-high); start/a/b/ula_control request; resultado/resultado_alto
// registered results, zero, busy, done (one-cycle pulse), div_zero.
// Build option: define ULA_DIVISAO_EN to include the restoring divider (opcode 11); otherwise 11 is ADD.
module ula_multiciclo #(
  parameter int WIDTH = 16,
  parameter int OP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  ula_control,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_alto,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {OCIOSO, MUL, DIV, FIM} estado_t;
  estado_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alto_q, alto_d, hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, alu;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dz_q, dz_d, is_mul, is_div;
  logic [WIDTH:0] msum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign is_mul = ula_control == OP_W'(10);
  // hi_q:lo_q is the partial product; lo_q starts as the multiplier and drains out as hi bits shift in
  assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi = msum[WIDTH:1];
  assign mul_lo = {msum[0], lo_q[WIDTH-1:1]};
`ifdef ULA_DIVISAO_EN
  logic [WIDTH:0] rsh, rsub;
  logic ge;
  logic [WIDTH-1:0] div_hi, div_lo;
  assign is_div = ula_control == OP_W'(11);
  // hi_q is the partial remainder, lo_q the dividend shifting out while quotient bits shift in;
  // with b == 0 every step subtracts nothing, leaving quotient all ones and remainder == a
  assign rsh = {hi_q, lo_q[WIDTH-1]};
  assign ge = rsh >= {1'b0, opb_q};
  assign rsub = ge ? rsh - {1'b0, opb_q} : rsh;
  assign div_hi = rsub[WIDTH-1:0];
  assign div_lo = {lo_q[WIDTH-2:0], ge};
`else
  assign is_div = 1'b0;
`endif
  always_comb begin
    case (ula_control)
      OP_W'(1): alu = a - b;
      OP_W'(2): alu = a & b;
      OP_W'(3): alu = a | b;
      OP_W'(4): alu = WIDTH'(a < b);
      OP_W'(5): alu = a ^ b;
      OP_W'(6): alu = a << b;
      OP_W'(7): alu = a >> b;
      OP_W'(8): alu = $unsigned($signed(a) >>> b);
      OP_W'(9): alu = WIDTH'($signed(a) < $signed(b));
      default:  alu = a + b;
    endcase
  end
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    alto_d = alto_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    case (state_q)
      OCIOSO: if (start) begin
        opb_d = b;
        hi_d = '0;
        lo_d = a;
        cnt_d = CW'(WIDTH - 1);
        if (is_mul) state_d = MUL;
        else if (is_div) state_d = DIV;
        else begin
          res_d = alu;
          alto_d = '0;
          dz_d = 1'b0;
          state_d = FIM;
        end
      end
      MUL: begin
        hi_d = mul_hi;
        lo_d = mul_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d = mul_lo;
          alto_d = mul_hi;
          dz_d = 1'b0;
          state_d = FIM;
        end
      end
`ifdef ULA_DIVISAO_EN
      DIV: begin
        hi_d = div_hi;
        lo_d = div_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d = div_lo;
          alto_d = div_hi;
          dz_d = opb_q == '0;
          state_d = FIM;
        end
      end
`endif
      default: state_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      res_q <= '0;
      alto_q <= '0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      alto_q <= alto_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end
  assign resultado = res_q;
  assign resultado_alto = alto_q;
  assign zero = res_q == '0;
  assign div_zero = dz_q;
  assign busy = state_q != OCIOSO;
  assign done = state_q == FIM;
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed and random checks of ula_multiciclo (WIDTH=16) against a behavioural model
module tb_ula_multiciclo;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [3:0] ula_control = '0;
  logic [15:0] resultado, resultado_alto;
  logic zero, busy, done, div_zero;
  int checks = 0, passed = 0;

  ula_multiciclo #(.WIDTH(16), .OP_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .ula_control(ula_control),
    .resultado(resultado), .resultado_alto(resultado_alto), .zero(zero), .busy(busy),
    .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output logic dz, output int lat);
    longint ux, uy, sx, sy, p;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lo = '0;
    hi = '0;
    dz = 1'b0;
    lat = 1;
    case (op)
      4'd1: lo = 16'(ux - uy);
      4'd2: lo = x & y;
      4'd3: lo = x | y;
      4'd4: lo = (ux < uy) ? 16'd1 : 16'd0;
      4'd5: lo = x ^ y;
      4'd6: lo = (uy >= 16) ? 16'd0 : 16'(ux << uy);
      4'd7: lo = 16'(ux >> uy);
      4'd8: lo = 16'(sx >>> ((uy > 63) ? 63 : uy));
      4'd9: lo = (sx < sy) ? 16'd1 : 16'd0;
      4'd10: begin
        p = ux * uy;
        lo = p[15:0];
        hi = p[31:16];
        lat = 17;
      end
`ifdef ULA_DIVISAO_EN
      4'd11: begin
        lat = 17;
        if (y == 0) begin
          lo = 16'hFFFF;
          hi = x;
          dz = 1'b1;
        end else begin
          lo = 16'(ux / uy);
          hi = 16'(ux % uy);
        end
      end
`endif
      default: lo = 16'(ux + uy);
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, input string tag);
    logic [15:0] elo, ehi;
    logic edz, busy_ok;
    int lat, n;
    model(op, x, y, elo, ehi, edz, lat);
    @(negedge clock);
    start = 1'b1;
    ula_control = op;
    a = x;
    b = y;
    @(negedge clock);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    ula_control = 4'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      busy_ok &= busy;
      @(negedge clock);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy"}, {31'd0, busy_ok & busy}, 1);
    chk({tag, " resultado"}, {16'd0, resultado}, {16'd0, elo});
    chk({tag, " resultado_alto"}, {16'd0, resultado_alto}, {16'd0, ehi});
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, elo == 16'd0});
    chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " resultado"}, {16'd0, resultado}, 0);
    chk({tag, " resultado_alto"}, {16'd0, resultado_alto}, 0);
    chk({tag, " zero"}, {31'd0, zero}, 1);
    chk({tag, " busy"}, {31'd0, busy}, 0);
    chk({tag, " done"}, {31'd0, done}, 0);
    chk({tag, " div_zero"}, {31'd0, div_zero}, 0);
  endtask

  initial begin
    logic [15:0] elo, ehi;
    logic edz;
    int lat, n, seen;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;

    run_op(4'd0, 16'hFFFF, 16'd1, "add_wrap");
    run_op(4'd10, 16'hFFFF, 16'hFFFF, "mul_max");
`ifdef ULA_DIVISAO_EN
    run_op(4'd11, 16'd100, 16'd7, "divu");
    run_op(4'd11, 16'd100, 16'd0, "divu_zero");
    run_op(4'd11, 16'hFFFF, 16'd1, "divu_one");
`else
    run_op(4'd11, 16'd3, 16'd4, "op11_add");
`endif
    run_op(4'd8, 16'h8000, 16'd20, "sra_big");
    run_op(4'd9, 16'hFFFF, 16'd1, "menor_s");
    run_op(4'd4, 16'hFFFF, 16'd1, "menor");
    run_op(4'd6, 16'h1234, 16'd16, "sll_big");
    run_op(4'd7, 16'h8001, 16'd15, "srl_15");
    run_op(4'd1, 16'd0, 16'd1, "sub_wrap");
    run_op(4'd14, 16'd9, 16'd6, "op14_add");

    // start pulsed with ADD mid-MUL must be ignored
    model(4'd10, 16'h1234, 16'h5678, elo, ehi, edz, lat);
    @(negedge clock);
    start = 1'b1;
    ula_control = 4'd10;
    a = 16'h1234;
    b = 16'h5678;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (n == 5) begin
        start = 1'b1;
        ula_control = 4'd0;
        a = 16'd1;
        b = 16'd1;
      end else start = 1'b0;
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    chk("ignore latency", n, 17);
    chk("ignore resultado", {16'd0, resultado}, {16'd0, elo});
    chk("ignore resultado_alto", {16'd0, resultado_alto}, {16'd0, ehi});
    @(negedge clock);
    chk("ignore idle after", {31'd0, busy}, 0);

    // reset mid-MUL aborts with no done
    start = 1'b1;
    ula_control = 4'd10;
    a = 16'h00FF;
    b = 16'h0101;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_reset_vals("abort");
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("abort no done", seen, 0);

    // start during reset is ignored
    reset = 1'b1;
    start = 1'b1;
    ula_control = 4'd0;
    a = 16'd5;
    b = 16'd5;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("start_in_reset busy", {31'd0, busy}, 0);
    @(negedge clock);
    chk("start_in_reset done", {31'd0, done}, 0);
    chk("start_in_reset resultado", {16'd0, resultado}, 0);

    // back-to-back with start held high
    start = 1'b1;
    ula_control = 4'd0;
    a = 16'd10;
    b = 16'd20;
    @(negedge clock);
    chk("b2b first done", {31'd0, done}, 1);
    chk("b2b first resultado", {16'd0, resultado}, 30);
    a = 16'd7;
    b = 16'd8;
    @(negedge clock);
    chk("b2b idle gap busy", {31'd0, busy}, 0);
    chk("b2b idle gap resultado", {16'd0, resultado}, 30);
    @(negedge clock);
    start = 1'b0;
    chk("b2b second done", {31'd0, done}, 1);
    chk("b2b second resultado", {16'd0, resultado}, 15);

    repeat (30) begin
      logic [3:0] op;
      logic [15:0] x, y;
      op = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      run_op(op, x, y, $sformatf("rand op%0d", op));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (legal 4..32).
REQ-002 Parameter OP_W, default 4, width of ula_control.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; operands and ula_control sampled when start=1 and busy=0.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 ula_control  input  OP_W  operation select.
REQ-008 resultado  output  WIDTH  registered primary result.
REQ-009 resultado_alto  output  WIDTH  registered secondary result (MUL high half, DIVU remainder, else 0).
REQ-010 zero  output  1  1 when resultado == 0.
REQ-011 busy  output  1  1 while an operation is in flight.
REQ-012 done  output  1  one-cycle pulse when resultado/resultado_alto become valid.
REQ-013 div_zero  output  1  registered with done; 1 when DIVU executed with b == 0.

Function
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MENOR (unsigned a<b ->1 else 0), 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 MENOR_S (signed two's-complement a<b), 10 MUL (unsigned), 11 DIVU (unsigned); 12-15 execute as ADD.
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-016 Shifts SHALL use full unsigned value of b; b >= WIDTH gives 0 for SLL/SRL and all copies of a[WIDTH-1] for SRA.
REQ-017 FSM states: OCIOSO, MUL, DIV, FIM; reset enters OCIOSO.
REQ-018 OCIOSO + accepted start with opcode 0-9 or 12-15: result computed and registered at that edge, go to FIM; done=1 the following cycle (latency 1).
REQ-019 OCIOSO + accepted start with MUL: go to MUL; iterative shift-add, one multiplier bit per cycle, WIDTH cycles, then FIM; done asserted exactly WIDTH+1 cycles after accept edge.
REQ-020 MUL SHALL yield full 2*WIDTH product: low half on resultado, high half on resultado_alto.
REQ-021 OCIOSO + accepted start with DIVU: go to DIV; restoring division, one quotient bit per cycle, WIDTH cycles, then FIM; done WIDTH+1 cycles after accept edge.
REQ-022 DIVU: resultado = quotient, resultado_alto = remainder.
REQ-023 DIVU with b == 0: resultado = all ones, resultado_alto = a, div_zero = 1, same latency as normal DIVU.
REQ-024 FIM lasts one cycle with done=1, then returns to OCIOSO; start in FIM ignored.
REQ-025 busy = 1 in MUL, DIV and FIM; busy = 0 in OCIOSO.
REQ-026 start while busy=1 SHALL be ignored; in-flight operands unaffected by later changes of a, b, ula_control.
REQ-027 resultado, resultado_alto, zero, div_zero SHALL hold their last values until the next done.
REQ-028 Back-to-back: start held high accepts a new operation in the first OCIOSO cycle after FIM.

Reset
REQ-029 On reset=1 at a clock edge: state OCIOSO, resultado=0, resultado_alto=0, zero=1, busy=0, done=0, div_zero=0, internal counters/accumulators cleared.
REQ-030 Reset asserted mid-MUL/DIV SHALL abort the operation; no done pulse for it.
REQ-031 start sampled in the same cycle as reset=1 SHALL be ignored.

Configuration
REQ-032 Macro ULA_DIVISAO_EN: when defined, DIVU and DIV state are built as in REQ-021..023.
REQ-033 Without ULA_DIVISAO_EN: no divider logic; opcode 11 executes as ADD with latency 1, div_zero constant 0.

Verification
REQ-034 WIDTH=16, ADD a=16'hFFFF b=1 -> done 1 cycle after accept, resultado=0, zero=1.
REQ-035 WIDTH=16, MUL a=16'hFFFF b=16'hFFFF -> done 17 cycles after accept, resultado=16'h0001, resultado_alto=16'hFFFE, busy high 17 cycles.
REQ-036 WIDTH=16, DIVU a=100 b=7 -> done after 17 cycles, resultado=14, resultado_alto=2, div_zero=0; b=0 -> resultado=16'hFFFF, resultado_alto=100, div_zero=1.
REQ-037 SRA a=16'h8000 b=20 -> resultado=16'hFFFF; MENOR_S a=16'hFFFF b=1 -> 1; MENOR same operands -> 0.
REQ-038 MUL started, start pulsed again with ADD at cycle 5 -> ignored, MUL result unchanged; reset at cycle 8 of new MUL -> no done, all outputs at reset values.
REQ-039 Build without ULA_DIVISAO_EN, opcode 11 a=3 b=4 -> resultado=7 after 1 cycle, div_zero=0.
